// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4 read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int unsigned ReqIfu = 0;
  localparam int unsigned ReqLsu = 1;

  // Width-independent part of an AR request; the address is held alongside
  // because its width follows the arbiter's AddrWidth parameter.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_pkt_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester-side (two packed ports) and memory-side AXI4 read bundles.
interface axi_rd_req_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  logic [1:0]             s_arvalid;
  logic [1:0]             s_arready;
  logic [2*AddrWidth-1:0] s_araddr;
  logic [15:0]            s_arlen;
  logic [5:0]             s_arsize;
  logic [3:0]             s_arburst;
  logic [1:0]             s_rvalid;
  logic [1:0]             s_rready;
  logic [DataWidth-1:0]   s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rlast;

  modport master (
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );

  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );
endinterface

interface axi_rd_mem_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  logic                 m_arid;
  logic [AddrWidth-1:0] m_araddr;
  logic [7:0]           m_arlen;
  logic [2:0]           m_arsize;
  logic [1:0]           m_arburst;
  logic                 m_arvalid;
  logic                 m_arready;
  logic                 m_rid;
  logic [DataWidth-1:0] m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic                 m_rvalid;
  logic                 m_rready;

  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; on a tie the port that did not win last is chosen.
module rr_arbiter2
  import axi_rd_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic       grant,
  output logic       gnt_valid
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt_valid    = |req;
    grant        = ~last_grant_q;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   grant = 1'(ReqIfu);
      2'b10:   grant = 1'(ReqLsu);
      default: grant = ~last_grant_q;
    endcase
    if (update_en && gnt_valid) begin
      last_grant_d = grant;
    end
  end

  // Reset to the LSU so the IFU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'(ReqLsu);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between IFU (port 0) and LSU (port 1), one
// transaction in flight, registered AR channel, R beats routed to the owner.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 64,
  parameter bit          ParamCheck = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_rd_req_if.slave  req,
  axi_rd_mem_if.master mem,
  output logic         busy,
  output logic         err
);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 arid_q, arid_d;
  logic                 arvalid_q, arvalid_d;
  logic [AddrWidth-1:0] araddr_q, araddr_d;
  ar_pkt_t              ctl_q, ctl_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic                 err_q, err_d;

  logic                 grant;
  logic                 gnt_valid;
  logic                 ar_hs;
  logic                 r_hs;
  logic [AddrWidth-1:0] addr_sel;
  ar_pkt_t              ctl_sel;
  logic [DataWidth-1:0] rdata_fwd;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req.s_arvalid),
    .update_en (state_q == IDLE),
    .grant     (grant),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    addr_sel      = grant ? req.s_araddr[2*AddrWidth-1:AddrWidth] : req.s_araddr[AddrWidth-1:0];
    ctl_sel.len   = grant ? req.s_arlen[15:8]  : req.s_arlen[7:0];
    ctl_sel.size  = grant ? req.s_arsize[5:3]  : req.s_arsize[2:0];
    ctl_sel.burst = grant ? req.s_arburst[3:2] : req.s_arburst[1:0];
  end

  assign ar_hs = (state_q == IDLE) && gnt_valid;
  assign r_hs  = (state_q == DATA) && mem.m_rvalid && mem.m_rready;

  assign req.s_arready = ar_hs ? port_onehot(grant) : '0;
  assign req.s_rvalid  = ((state_q == DATA) && mem.m_rvalid) ? port_onehot(owner_q) : '0;
  assign mem.m_rready  = (state_q == DATA) && req.s_rready[owner_q];

  assign rdata_fwd     = mem.m_rdata;
  assign req.s_rdata   = rdata_fwd;
  assign req.s_rresp   = mem.m_rresp;
  assign req.s_rlast   = mem.m_rlast;

  assign mem.m_arid    = arid_q;
  assign mem.m_araddr  = araddr_q;
  assign mem.m_arlen   = ctl_q.len;
  assign mem.m_arsize  = ctl_q.size;
  assign mem.m_arburst = ctl_q.burst;
  assign mem.m_arvalid = arvalid_q;

  assign busy = (state_q != IDLE);
  assign err  = err_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    arid_d     = arid_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    ctl_d      = ctl_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          araddr_d   = addr_sel;
          ctl_d      = ctl_sel;
          arid_d     = grant;
          owner_d    = grant;
          beat_cnt_d = '0;
          arvalid_d  = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_q && mem.m_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (mem.m_rlast) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // beat_cnt_q counts beats already accepted, so the final beat sees beat_cnt_q == len.
  always_comb begin
    err_d = 1'b0;
    if (ParamCheck) begin
      err_d = (r_hs && (mem.m_rid != owner_q))
           || (r_hs &&  mem.m_rlast && (beat_cnt_q != ctl_q.len))
           || (r_hs && !mem.m_rlast && (beat_cnt_q == ctl_q.len))
           || (mem.m_rvalid && (state_q != DATA));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'(ReqIfu);
      arid_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      ctl_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      arid_q     <= arid_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      ctl_q      <= ctl_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter against a transaction-level reference model.
module tb_axi_rd_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  axi_rd_req_if #(.AddrWidth(AW), .DataWidth(DW)) req_if ();
  axi_rd_mem_if #(.AddrWidth(AW), .DataWidth(DW)) mem_if ();

  axi_rd_arbiter #(.AddrWidth(AW), .DataWidth(DW), .ParamCheck(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_if),
    .mem   (mem_if),
    .busy  (busy),
    .err   (err)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: last winner, pending err pulse, per-port request payloads.
  logic          last_m  = 1'b1;
  logic          err_exp = 1'b0;
  logic [AW-1:0] pa [2];
  logic [7:0]    pl [2];
  logic [2:0]    ps [2];
  logic [1:0]    pb [2];

  task automatic new_payload(input int p);
    pa[p] = $urandom;
    pl[p] = 8'($urandom_range(7));
    ps[p] = 3'($urandom_range(7));
    pb[p] = 2'($urandom_range(2));
  endtask

  task automatic drive_payload();
    req_if.s_araddr  = {pa[1], pa[0]};
    req_if.s_arlen   = {pl[1], pl[0]};
    req_if.s_arsize  = {ps[1], ps[0]};
    req_if.s_arburst = {pb[1], pb[0]};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_if.s_arvalid = 2'b00;
      req_if.s_rready  = 2'($urandom_range(3));
      mem_if.m_rvalid  = 1'b0;
      mem_if.m_arready = 1'b0;
      #1;
      total++;
      if (err !== err_exp) begin bad++; $display("FAIL err_idle: got %b want %b", err, err_exp); end
      err_exp = 1'b0;
      total++;
      if ({busy, req_if.s_arready, req_if.s_rvalid, mem_if.m_rready, mem_if.m_arvalid} !== 7'b0) begin
        bad++;
        $display("FAIL idle_outputs: got busy=%b arready=%b rvalid=%b rready=%b arvalid=%b want all 0",
                 busy, req_if.s_arready, req_if.s_rvalid, mem_if.m_rready, mem_if.m_arvalid);
      end
    end
  endtask

  // One full transaction: request cycle, AR phase, R phase. nbeats < 0 means len+1.
  task automatic run_txn(input logic [1:0] reqm, input int ar_stall, input int nbeats,
                         input logic bad_rid, input int gap_pct, input int rstall_pct,
                         input int rhold, input int abort_at,
                         output logic gnt, output int delivered);
    logic [AW-1:0] ea;
    logic [7:0]    el;
    logic [2:0]    es;
    logic [1:0]    eb;
    logic [1:0]    oh;
    logic          rv, rl, rid, hs, aborted;
    logic [DW-1:0] rd;
    logic [1:0]    rr, rresp;
    int            beats, guard, nb, rh;

    gnt = (reqm == 2'b11) ? ~last_m : reqm[1];
    oh  = gnt ? 2'b10 : 2'b01;
    ea = pa[gnt]; el = pl[gnt]; es = ps[gnt]; eb = pb[gnt];
    nb = (nbeats < 0) ? int'(el) + 1 : nbeats;
    rh = rhold;
    delivered = 0;
    aborted = 1'b0;

    @(negedge clk);
    req_if.s_arvalid = reqm;
    drive_payload();
    req_if.s_rready  = 2'b00;
    mem_if.m_arready = 1'b0;
    mem_if.m_rvalid  = 1'b0;
    #1;
    total++;
    if (err !== err_exp) begin bad++; $display("FAIL err_req: got %b want %b", err, err_exp); end
    err_exp = 1'b0;
    total++;
    if ({busy, req_if.s_arready} !== {1'b0, oh}) begin
      bad++; $display("FAIL grant: got busy=%b arready=%b want busy=0 arready=%b", busy, req_if.s_arready, oh);
    end
    last_m = gnt;

    for (int i = 0; i <= ar_stall; i++) begin
      @(negedge clk);
      req_if.s_arvalid = reqm & ~oh;
      if (i == 0) begin new_payload(int'(gnt)); drive_payload(); end
      mem_if.m_arready = (i == ar_stall);
      #1;
      total++;
      if (err !== err_exp) begin bad++; $display("FAIL err_addr: got %b want %b", err, err_exp); end
      err_exp = 1'b0;
      total++;
      if ({mem_if.m_arvalid, mem_if.m_arid, mem_if.m_araddr, mem_if.m_arlen, mem_if.m_arsize,
           mem_if.m_arburst, req_if.s_arready, busy} !== {1'b1, gnt, ea, el, es, eb, 2'b00, 1'b1}) begin
        bad++;
        $display("FAIL ar_channel: cyc=%0d got v=%b id=%b a=%h l=%0d s=%0d b=%0d rdy=%b busy=%b want v=1 id=%b a=%h l=%0d s=%0d b=%0d rdy=00 busy=1",
                 i, mem_if.m_arvalid, mem_if.m_arid, mem_if.m_araddr, mem_if.m_arlen, mem_if.m_arsize,
                 mem_if.m_arburst, req_if.s_arready, busy, gnt, ea, el, es, eb);
      end
    end

    beats = 0; guard = 0; hs = 1'b0; rl = 1'b0;
    while (!(hs && rl) && guard < 2000) begin
      guard++;
      @(negedge clk);
      mem_if.m_arready = 1'b0;
      if (abort_at >= 0 && beats == abort_at) begin
        rst_n = 1'b0;
        mem_if.m_rvalid  = 1'b0;
        req_if.s_arvalid = 2'b00;
        req_if.s_rready  = 2'b00;
        #1;
        total++;
        if (err !== err_exp) begin bad++; $display("FAIL err_abort: got %b want %b", err, err_exp); end
        @(negedge clk);
        #1;
        total++;
        if ({busy, mem_if.m_arvalid, req_if.s_arready, err} !== 5'b0) begin
          bad++; $display("FAIL reset_mid: got busy=%b arvalid=%b arready=%b err=%b want all 0",
                          busy, mem_if.m_arvalid, req_if.s_arready, err);
        end
        rst_n = 1'b1;
        last_m = 1'b1;
        err_exp = 1'b0;
        aborted = 1'b1;
        break;
      end
      rv    = ($urandom_range(99) >= gap_pct);
      rl    = (beats == nb - 1);
      rid   = bad_rid ? ~gnt : gnt;
      rd    = {$urandom, $urandom};
      rresp = 2'($urandom_range(3));
      rr    = 2'($urandom_range(3));
      rr[gnt] = ($urandom_range(99) >= rstall_pct);
      if (beats == 1 && rh > 0) begin rr[gnt] = 1'b0; rv = 1'b1; rh--; end
      mem_if.m_rvalid = rv;
      mem_if.m_rdata  = rd;
      mem_if.m_rresp  = rresp;
      mem_if.m_rlast  = rl;
      mem_if.m_rid    = rid;
      req_if.s_rready = rr;
      #1;
      total++;
      if (err !== err_exp) begin bad++; $display("FAIL err_data: got %b want %b", err, err_exp); end
      err_exp = 1'b0;
      total++;
      if ({req_if.s_rvalid, mem_if.m_rready, req_if.s_rdata, req_if.s_rresp, req_if.s_rlast,
           req_if.s_arready, busy, mem_if.m_arvalid} !== {(rv ? oh : 2'b00), rr[gnt], rd, rresp, rl, 2'b00, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL r_route: beat=%0d got rvalid=%b rready=%b data=%h resp=%b last=%b arrdy=%b busy=%b arv=%b want rvalid=%b rready=%b data=%h resp=%b last=%b",
                 beats, req_if.s_rvalid, mem_if.m_rready, req_if.s_rdata, req_if.s_rresp, req_if.s_rlast,
                 req_if.s_arready, busy, mem_if.m_arvalid, (rv ? oh : 2'b00), rr[gnt], rd, rresp, rl);
      end
      if (req_if.s_rvalid[gnt] && rr[gnt]) delivered++;
      hs = rv && rr[gnt];
      if (hs) begin
        err_exp = bad_rid || (rl && 8'(beats) != el) || (!rl && 8'(beats) == el);
        beats++;
      end
    end
    if (guard >= 2000) begin
      total++; bad++; $display("FAIL r_timeout: got %0d beats want %0d", beats, nb);
    end
    if (!aborted) begin
      total++;
      if (delivered !== nb) begin bad++; $display("FAIL beat_count: got %0d want %0d", delivered, nb); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_if.s_arvalid = 2'b00;
    req_if.s_rready  = 2'b00;
    mem_if.m_arready = 1'b0;
    mem_if.m_rvalid  = 1'b0;
    mem_if.m_rlast   = 1'b0;
    mem_if.m_rid     = 1'b0;
    mem_if.m_rdata   = '0;
    mem_if.m_rresp   = 2'b00;
    new_payload(0); new_payload(1); drive_payload();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, err, mem_if.m_arvalid, mem_if.m_arid, mem_if.m_araddr, mem_if.m_arlen, mem_if.m_arsize,
         mem_if.m_arburst, req_if.s_arready, req_if.s_rvalid, mem_if.m_rready} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b err=%b arv=%b id=%b a=%h l=%0d s=%0d b=%0d want all 0",
               busy, err, mem_if.m_arvalid, mem_if.m_arid, mem_if.m_araddr, mem_if.m_arlen,
               mem_if.m_arsize, mem_if.m_arburst);
    end
    rst_n = 1'b1;
    last_m = 1'b1;
    err_exp = 1'b0;
  endtask

  task automatic test_ifu_single();
    logic g; int d;
    pa[0] = 32'h0000_1000; pl[0] = 8'd3; ps[0] = 3'd3; pb[0] = 2'd1;
    run_txn(2'b01, 0, 4, 1'b0, 0, 0, 0, -1, g, d);
    total++;
    if (d !== 4) begin bad++; $display("FAIL ifu_beats: got %0d want 4", d); end
    idle_cycles(2);
  endtask

  task automatic test_tie();
    logic g; int d;
    idle_cycles(1);
    new_payload(0); new_payload(1);
    run_txn(2'b11, 0, -1, 1'b0, 20, 20, 0, -1, g, d);
    run_txn(2'b10, 0, -1, 1'b0, 20, 20, 0, -1, g, d);
    run_txn(2'b11, 1, -1, 1'b0, 20, 20, 0, -1, g, d);
  endtask

  task automatic test_ar_stall();
    logic g; int d;
    run_txn(2'b11, 5, -1, 1'b0, 0, 0, 0, -1, g, d);
  endtask

  task automatic test_rready_stall();
    logic g; int d;
    pl[1] = 8'd1;
    run_txn(2'b10, 0, 2, 1'b0, 0, 0, 3, -1, g, d);
    total++;
    if (d !== 2) begin bad++; $display("FAIL lsu_beats: got %0d want 2", d); end
  endtask

  task automatic test_errors();
    logic g; int d;
    pl[0] = 8'd3;
    run_txn(2'b01, 0, 3, 1'b0, 0, 0, 0, -1, g, d);
    idle_cycles(2);
    pl[1] = 8'd1;
    run_txn(2'b10, 0, 2, 1'b1, 0, 0, 0, -1, g, d);
    pl[0] = 8'd1;
    run_txn(2'b01, 1, 3, 1'b0, 10, 10, 0, -1, g, d);
    idle_cycles(1);
    @(negedge clk);
    mem_if.m_rvalid = 1'b1;
    #1;
    total++;
    if (err !== err_exp) begin bad++; $display("FAIL err_stray_pre: got %b want %b", err, err_exp); end
    total++;
    if ({req_if.s_rvalid, mem_if.m_rready} !== 3'b000) begin
      bad++; $display("FAIL stray_rvalid: got rvalid=%b rready=%b want 00/0", req_if.s_rvalid, mem_if.m_rready);
    end
    err_exp = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    logic g; int d;
    pl[0] = 8'd3;
    run_txn(2'b01, 0, 4, 1'b0, 0, 0, 0, 2, g, d);
    pa[0] = 32'h0000_2000; pl[0] = 8'd2;
    run_txn(2'b01, 0, 3, 1'b0, 0, 0, 0, -1, g, d);
    total++;
    if (d !== 3) begin bad++; $display("FAIL post_reset_beats: got %0d want 3", d); end
  endtask

  task automatic test_random();
    logic [1:0] pend;
    logic g; int d;
    pend = 2'b00;
    for (int t = 0; t < 30; t++) begin
      pend = pend | 2'($urandom_range(1, 3));
      run_txn(pend, $urandom_range(3), -1, 1'b0, 30, 30, 0, -1, g, d);
      pend = pend & ~(g ? 2'b10 : 2'b01);
      if ($urandom_range(3) == 0) begin
        pend = 2'b00;
        idle_cycles(1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ifu_single();
    test_tie();
    test_ar_stall();
    test_rready_stall();
    test_errors();
    test_reset_mid();
    test_random();
    idle_cycles(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
